// File: rtl/rx_ipv4_parser_if.sv
// Byte-stream bus between the MAC receive path and the IPv4 parser.
// slave: the parser side; master: the side feeding bytes and consuming results.
interface rx_ipv4_parser_if #(
    parameter int NPROTO = 3
);
    logic              rx_payload_ipv4;
    logic [7:0]        rx_payload;
    logic [7:0]        rx_data;
    logic [NPROTO-1:0] rx_data_valid;
    logic              rx_data_last;
    logic [31:0]       rx_src_ip;
    logic [15:0]       rx_payload_len;
    logic              rx_pkt_done;
    logic              rx_err;
    logic [2:0]        rx_err_code;

    modport slave (
        input  rx_payload_ipv4, rx_payload,
        output rx_data, rx_data_valid, rx_data_last, rx_src_ip,
               rx_payload_len, rx_pkt_done, rx_err, rx_err_code
    );

    modport master (
        output rx_payload_ipv4, rx_payload,
        input  rx_data, rx_data_valid, rx_data_last, rx_src_ip,
               rx_payload_len, rx_pkt_done, rx_err, rx_err_code
    );
endinterface

// File: rtl/rx_ipv4_parser.sv
// IPv4 receive parser: collects the header (with options), verifies the
// one's-complement checksum, destination, fragmentation and protocol, then
// forwards total_len-IHL*4 payload bytes on the lane of the matching protocol.
// Trailing padding is swallowed; a strobe drop mid-packet reports truncation.
module rx_ipv4_parser #(
    parameter int                  OCT          = 8,
    parameter int                  NPROTO       = 3,
    parameter logic [NPROTO*8-1:0] PROTO_LIST   = {8'h01, 8'h06, 8'h11},
    parameter bit                  ACCEPT_BCAST = 1'b1
) (
    input  logic                  RX_CLK,
    input  logic                  rst,
    input  logic [31:0]           ip_addr,
    rx_ipv4_parser_if.slave       bus
);
    typedef enum logic [2:0] {IDLE, HDR, OPT, DATA, DROP} state_t;

    state_t          state;
    logic [5:0]      hcnt;       // header byte index, up to 59
    logic [15:0]     csum;       // running one's-complement sum
    logic [OCT-1:0]  hi;         // high byte of the word being assembled
    logic [3:0]      ver, ihl;
    logic [15:0]     tot_len;
    logic [13:0]     frag;       // MF + fragment offset
    logic [7:0]      proto;
    logic [31:0]     src, dst, ip_q;
    logic            chk;        // first DATA cycle: header verdict is due
    logic [15:0]     cnt;        // payload bytes still to forward

    logic            stb;
    logic [7:0]      b;
    logic [16:0]     csum_sum;
    logic [15:0]     csum_nxt;
    logic [5:0]      hdr_last;
    logic [15:0]     hlen, plen;
    logic [NPROTO-1:0] proto_sel;
    logic            found;
    logic [2:0]      chk_code;

    assign stb      = bus.rx_payload_ipv4;
    assign b        = bus.rx_payload;
    assign csum_sum = {1'b0, csum} + {1'b0, hi, b};
    // A single fold cannot overflow again: max 16'hFFFE + 1.
    assign csum_nxt = csum_sum[15:0] + {15'd0, csum_sum[16]};
    assign hdr_last = {ihl, 2'b00} - 6'd1;
    assign hlen     = {10'd0, ihl, 2'b00};
    assign plen     = tot_len - hlen;

    // First-match protocol lookup keeps rx_data_valid one-hot even with duplicates.
    always_comb begin
        proto_sel = '0;
        found     = 1'b0;
        for (int i = 0; i < NPROTO; i++) begin
            if (!found && PROTO_LIST[8*i +: 8] == proto) begin
                proto_sel[i] = 1'b1;
                found        = 1'b1;
            end
        end
    end

    // Header verdict in priority order; 0 means accept.
    always_comb begin
        chk_code = 3'd0;
        if (ver != 4'd4 || ihl < 4'd5)
            chk_code = 3'd1;
        else if (tot_len < hlen)
            chk_code = 3'd7;
        else if (csum != 16'hFFFF)
            chk_code = 3'd2;
        else if (!(dst == ip_q || (ACCEPT_BCAST && dst == 32'hFFFF_FFFF)))
            chk_code = 3'd3;
        else if (frag[13] || frag[12:0] != 13'd0)
            chk_code = 3'd5;
        else if (proto_sel == '0)
            chk_code = 3'd4;
    end

    // Parser FSM with registered outputs.
    always_ff @(posedge RX_CLK) begin
        if (rst) begin
            state              <= IDLE;
            hcnt               <= '0;
            csum               <= '0;
            hi                 <= '0;
            ver                <= '0;
            ihl                <= '0;
            tot_len            <= '0;
            frag               <= '0;
            proto              <= '0;
            src                <= '0;
            dst                <= '0;
            ip_q               <= '0;
            chk                <= 1'b0;
            cnt                <= '0;
            bus.rx_data        <= '0;
            bus.rx_data_valid  <= '0;
            bus.rx_data_last   <= 1'b0;
            bus.rx_src_ip      <= '0;
            bus.rx_payload_len <= '0;
            bus.rx_pkt_done    <= 1'b0;
            bus.rx_err         <= 1'b0;
            bus.rx_err_code    <= '0;
        end else begin
            bus.rx_data_valid <= '0;
            bus.rx_data_last  <= 1'b0;
            bus.rx_pkt_done   <= 1'b0;
            bus.rx_err        <= 1'b0;
            case (state)
                IDLE: if (stb) begin
                    ver   <= b[7:4];
                    ihl   <= b[3:0];
                    hi    <= b;
                    csum  <= '0;
                    hcnt  <= 6'd1;
                    state <= HDR;
                end
                HDR, OPT: if (!stb) begin
                    bus.rx_err      <= 1'b1;
                    bus.rx_err_code <= 3'd6;
                    state           <= IDLE;
                end else begin
                    if (!hcnt[0]) hi <= b;
                    else          csum <= csum_nxt;
                    hcnt <= hcnt + 6'd1;
                    if (state == HDR) begin
                        case (hcnt)
                            6'd2, 6'd3:   tot_len    <= {tot_len[7:0], b};
                            6'd6:         frag[13:8] <= b[5:0];
                            6'd7:         frag[7:0]  <= b;
                            6'd9:         proto      <= b;
                            6'd12, 6'd13,
                            6'd14, 6'd15: src        <= {src[23:0], b};
                            6'd16, 6'd17,
                            6'd18, 6'd19: dst        <= {dst[23:0], b};
                            default: ;
                        endcase
                    end
                    // IHL<5 skips options and is judged right after byte 19.
                    if ((state == HDR && hcnt == 6'd19 && ihl <= 4'd5) ||
                        (state == OPT && hcnt == hdr_last)) begin
                        ip_q  <= ip_addr;
                        chk   <= 1'b1;
                        state <= DATA;
                    end else if (state == HDR && hcnt == 6'd19) begin
                        state <= OPT;
                    end
                end
                DATA: if (chk) begin
                    chk <= 1'b0;
                    if (chk_code != 3'd0) begin
                        bus.rx_err      <= 1'b1;
                        bus.rx_err_code <= chk_code;
                        state           <= stb ? DROP : IDLE;
                    end else begin
                        bus.rx_src_ip      <= src;
                        bus.rx_payload_len <= plen;
                        if (plen == 16'd0) begin
                            bus.rx_pkt_done <= 1'b1;
                            state           <= stb ? DROP : IDLE;
                        end else if (!stb) begin
                            bus.rx_err      <= 1'b1;
                            bus.rx_err_code <= 3'd6;
                            state           <= IDLE;
                        end else begin
                            bus.rx_data       <= b;
                            bus.rx_data_valid <= proto_sel;
                            cnt               <= plen - 16'd1;
                            if (plen == 16'd1) begin
                                bus.rx_data_last <= 1'b1;
                                bus.rx_pkt_done  <= 1'b1;
                                state            <= DROP;
                            end
                        end
                    end
                end else if (!stb) begin
                    bus.rx_err      <= 1'b1;
                    bus.rx_err_code <= 3'd6;
                    state           <= IDLE;
                end else begin
                    bus.rx_data       <= b;
                    bus.rx_data_valid <= proto_sel;
                    cnt               <= cnt - 16'd1;
                    if (cnt == 16'd1) begin
                        bus.rx_data_last <= 1'b1;
                        bus.rx_pkt_done  <= 1'b1;
                        state            <= DROP;
                    end
                end
                DROP: if (!stb) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rx_ipv4_parser.sv
// Directed bench: two parsers (broadcast accepted / rejected) see the same
// byte stream; a table of packets with hand-computed outcomes plus a few
// hand-written multi-packet and reset sequences.
module tb_rx_ipv4_parser;
    // Protocol list ordered so ICMP is entry 0, TCP entry 1, UDP entry 2.
    localparam logic [23:0] PL    = {8'h11, 8'h06, 8'h01};
    localparam logic [31:0] MY_IP = 32'hC0A8_0164;
    localparam logic [31:0] SRC   = 32'h0A00_0002;

    logic        RX_CLK = 1'b0;
    logic        rst    = 1'b1;
    logic [31:0] ip_addr = MY_IP;
    logic        stb    = 1'b0;
    logic [7:0]  pb     = 8'h00;

    always #5 RX_CLK = ~RX_CLK;

    rx_ipv4_parser_if #(.NPROTO(3)) ifa ();
    rx_ipv4_parser_if #(.NPROTO(3)) ifb ();
    assign ifa.rx_payload_ipv4 = stb;
    assign ifa.rx_payload      = pb;
    assign ifb.rx_payload_ipv4 = stb;
    assign ifb.rx_payload      = pb;

    rx_ipv4_parser #(.OCT(8), .NPROTO(3), .PROTO_LIST(PL), .ACCEPT_BCAST(1'b1)) dut_a (
        .RX_CLK(RX_CLK), .rst(rst), .ip_addr(ip_addr), .bus(ifa.slave));
    rx_ipv4_parser #(.OCT(8), .NPROTO(3), .PROTO_LIST(PL), .ACCEPT_BCAST(1'b0)) dut_b (
        .RX_CLK(RX_CLK), .rst(rst), .ip_addr(ip_addr), .bus(ifb.slave));

    typedef struct {
        logic [3:0]  ver, ihl;
        logic [15:0] tlen, frag;
        logic [7:0]  proto;
        logic [31:0] dst;
        int          after;     // bytes streamed after the header
        int          hcut;      // nonzero: only this many header bytes
        bit          flip;      // corrupt one checksum bit
        int          exp_nd;
        logic [2:0]  exp_code, exp_code_b, exp_vb;
        logic [15:0] exp_len;
    } vec_t;

    int n_cmp = 0, n_bad = 0;

    // Observed per DUT (0 = broadcast accepted, 1 = rejected)
    int nd[2], nerr[2], ndone[2], nlast[2], idx[2];
    int dmis = 0, nviol = 0;
    logic [2:0] vor[2], ecode[2];

    // Output monitor, sampled mid-cycle
    always @(negedge RX_CLK) begin
        logic [2:0] vv[2];
        logic [7:0] dd[2];
        logic       ll[2], dn[2], er[2];
        logic [2:0] cc[2];
        vv[0] = ifa.rx_data_valid; dd[0] = ifa.rx_data; ll[0] = ifa.rx_data_last;
        dn[0] = ifa.rx_pkt_done;   er[0] = ifa.rx_err;  cc[0] = ifa.rx_err_code;
        vv[1] = ifb.rx_data_valid; dd[1] = ifb.rx_data; ll[1] = ifb.rx_data_last;
        dn[1] = ifb.rx_pkt_done;   er[1] = ifb.rx_err;  cc[1] = ifb.rx_err_code;
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                if (|vv[k]) begin
                    if (dd[k] !== 8'h30 + 8'(idx[k])) dmis++;
                    nd[k]++;
                    idx[k]++;
                    vor[k] = vor[k] | vv[k];
                end
                if ($countones(vv[k]) > 1 || (|vv[k] && er[k])) nviol++;
                if (ll[k] && !(dn[k] && |vv[k])) nviol++;
                if (ll[k] && dn[k]) nlast[k]++;
                if (dn[k]) begin ndone[k]++; idx[k] = 0; end
                if (er[k]) begin nerr[k]++; ecode[k] = cc[k]; end
            end
        end
    end

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic clear_mon();
        for (int k = 0; k < 2; k++) begin
            nd[k] = 0; nerr[k] = 0; ndone[k] = 0; nlast[k] = 0; idx[k] = 0;
            vor[k] = 3'b000; ecode[k] = 3'd0;
        end
        dmis = 0;
    endtask

    task automatic send_byte(input logic [7:0] v);
        stb = 1'b1;
        pb  = v;
        @(posedge RX_CLK);
        #1;
    endtask

    task automatic idle(input int n);
        stb = 1'b0;
        pb  = 8'h00;
        repeat (n) @(posedge RX_CLK);
        #1;
    endtask

    // Builds the header with a correct checksum (unless flipped) and streams it;
    // leaves the strobe high so callers decide how the frame ends.
    task automatic send_pkt(input vec_t t);
        logic [7:0]  h[60];
        logic [15:0] ck;
        int hl, s, n;
        hl = (t.ihl < 4'd5) ? 20 : int'(t.ihl) * 4;
        for (int i = 0; i < 60; i++) h[i] = 8'h00;
        h[0] = {t.ver, t.ihl};
        h[2] = t.tlen[15:8]; h[3] = t.tlen[7:0];
        h[4] = 8'h12;        h[5] = 8'h34;
        h[6] = t.frag[15:8]; h[7] = t.frag[7:0];
        h[8] = 8'h40;        h[9] = t.proto;
        for (int i = 0; i < 4; i++) begin
            h[12+i] = SRC[31-8*i -: 8];
            h[16+i] = t.dst[31-8*i -: 8];
        end
        for (int i = 20; i < hl; i++) h[i] = 8'hA0 ^ 8'(i);
        s = 0;
        for (int i = 0; i < hl; i += 2) s += int'({h[i], h[i+1]});
        while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >>> 16);
        ck = ~s[15:0];
        h[10] = ck[15:8];
        h[11] = ck[7:0];
        if (t.flip) h[11][0] = ~h[11][0];
        n = (t.hcut != 0) ? t.hcut : hl;
        for (int i = 0; i < n; i++) send_byte(h[i]);
        for (int i = 0; i < t.after; i++) send_byte(8'h30 + 8'(i));
    endtask

    function automatic vec_t mk(input logic [3:0] ver, input logic [3:0] ihl,
                                input logic [15:0] tlen, input logic [15:0] frag,
                                input logic [7:0] proto, input logic [31:0] dst,
                                input int after, input int hcut, input bit flip,
                                input int exp_nd, input logic [2:0] exp_code,
                                input logic [2:0] exp_code_b, input logic [2:0] exp_vb,
                                input logic [15:0] exp_len);
        vec_t t;
        t.ver = ver; t.ihl = ihl; t.tlen = tlen; t.frag = frag; t.proto = proto;
        t.dst = dst; t.after = after; t.hcut = hcut; t.flip = flip;
        t.exp_nd = exp_nd; t.exp_code = exp_code; t.exp_code_b = exp_code_b;
        t.exp_vb = exp_vb; t.exp_len = exp_len;
        return t;
    endfunction

    vec_t tv[17];

    initial begin
        //          ver ihl  tlen   frag      proto  dst            aft cut fl nd code cb  vb      len
        tv[0]  = mk(4, 5,  16'd28, 16'h0000, 8'h11, MY_IP,          8, 0, 0, 8, 0, 0, 3'b100, 16'd8);  // UDP ok
        tv[1]  = mk(4, 5,  16'd28, 16'h0000, 8'h11, MY_IP,          8, 0, 1, 0, 2, 2, 3'b000, 16'd0);  // bad csum
        tv[2]  = mk(4, 6,  16'd32, 16'h0000, 8'h11, MY_IP,          8, 0, 0, 8, 0, 0, 3'b100, 16'd8);  // 4-byte option
        tv[3]  = mk(4, 5,  16'd28, 16'h0000, 8'h11, MY_IP,         26, 0, 0, 8, 0, 0, 3'b100, 16'd8);  // 18B padding
        tv[4]  = mk(4, 5,  16'd28, 16'h0000, 8'h11, 32'hFFFF_FFFF,  8, 0, 0, 8, 0, 3, 3'b100, 16'd8);  // broadcast
        tv[5]  = mk(4, 5,  16'd28, 16'h0001, 8'h11, MY_IP,          8, 0, 0, 0, 5, 5, 3'b000, 16'd0);  // frag off 1
        tv[6]  = mk(4, 5,  16'd28, 16'h2000, 8'h11, MY_IP,          8, 0, 0, 0, 5, 5, 3'b000, 16'd0);  // MF set
        tv[7]  = mk(4, 5,  16'd28, 16'h0000, 8'h02, MY_IP,          8, 0, 0, 0, 4, 4, 3'b000, 16'd0);  // proto 2
        tv[8]  = mk(6, 5,  16'd28, 16'h0000, 8'h11, MY_IP,          8, 0, 0, 0, 1, 1, 3'b000, 16'd0);  // version 6
        tv[9]  = mk(4, 4,  16'd28, 16'h0000, 8'h11, MY_IP,          8, 0, 0, 0, 1, 1, 3'b000, 16'd0);  // IHL 4
        tv[10] = mk(4, 5,  16'd16, 16'h0000, 8'h11, MY_IP,          8, 0, 0, 0, 7, 7, 3'b000, 16'd0);  // tlen < hdr
        tv[11] = mk(4, 5,  16'd28, 16'h0000, 8'h11, 32'hC0A8_0165,  8, 0, 0, 0, 3, 3, 3'b000, 16'd0);  // wrong dst
        tv[12] = mk(4, 5,  16'd24, 16'h0000, 8'h06, MY_IP,          4, 0, 0, 4, 0, 0, 3'b010, 16'd4);  // TCP
        tv[13] = mk(4, 5,  16'd20, 16'h0000, 8'h01, MY_IP,          0, 0, 0, 0, 0, 0, 3'b000, 16'd0);  // ICMP, len 0
        tv[14] = mk(4, 5,  16'd28, 16'h0000, 8'h11, MY_IP,          3, 0, 0, 3, 6, 6, 3'b100, 16'd0);  // cut in data
        tv[15] = mk(4, 15, 16'd64, 16'h0000, 8'h11, MY_IP,          4, 0, 0, 4, 0, 0, 3'b100, 16'd4);  // 60B header
        tv[16] = mk(4, 5,  16'd28, 16'h0000, 8'h11, MY_IP,          0, 10, 0, 0, 6, 6, 3'b000, 16'd0); // cut in hdr

        clear_mon();
        repeat (3) @(posedge RX_CLK);
        #1;
        cmp("reset ctl", {29'd0, ifa.rx_data_valid} | {ifa.rx_data, ifa.rx_data_last,
            ifa.rx_pkt_done, ifa.rx_err, ifa.rx_err_code, 3'b000}, 32'd0);
        cmp("reset src", ifa.rx_src_ip, 32'd0);
        cmp("reset len", {16'd0, ifa.rx_payload_len}, 32'd0);
        rst = 1'b0;
        idle(2);

        for (int i = 0; i < 17; i++) begin
            clear_mon();
            send_pkt(tv[i]);
            idle(4);
            cmp($sformatf("v%0d ndata", i), nd[0], tv[i].exp_nd);
            cmp($sformatf("v%0d code", i), {29'd0, ecode[0]}, {29'd0, tv[i].exp_code});
            cmp($sformatf("v%0d nerr", i), nerr[0], (tv[i].exp_code != 3'd0) ? 1 : 0);
            cmp($sformatf("v%0d done", i), ndone[0], (tv[i].exp_code == 3'd0) ? 1 : 0);
            cmp($sformatf("v%0d last", i), nlast[0],
                (tv[i].exp_code == 3'd0 && tv[i].exp_nd > 0) ? 1 : 0);
            cmp($sformatf("v%0d vbits", i), {29'd0, vor[0]}, {29'd0, tv[i].exp_vb});
            cmp($sformatf("v%0d bytes", i), dmis, 0);
            cmp($sformatf("v%0d nobc code", i), {29'd0, ecode[1]}, {29'd0, tv[i].exp_code_b});
            cmp($sformatf("v%0d nobc done", i), ndone[1], (tv[i].exp_code_b == 3'd0) ? 1 : 0);
            if (tv[i].exp_code == 3'd0) begin
                cmp($sformatf("v%0d src", i), ifa.rx_src_ip, SRC);
                cmp($sformatf("v%0d len", i), {16'd0, ifa.rx_payload_len}, {16'd0, tv[i].exp_len});
            end
        end

        // Back-to-back: UDP then TCP separated by a single low-strobe cycle
        clear_mon();
        send_pkt(tv[0]);
        idle(1);
        send_pkt(tv[12]);
        idle(4);
        cmp("b2b ndata", nd[0], 12);
        cmp("b2b done", ndone[0], 2);
        cmp("b2b nerr", nerr[0], 0);
        cmp("b2b vbits", {29'd0, vor[0]}, {29'd0, 3'b110});
        cmp("b2b bytes", dmis, 0);

        // Padding then a fresh packet right after one idle cycle
        clear_mon();
        send_pkt(tv[3]);
        idle(1);
        send_pkt(tv[0]);
        idle(4);
        cmp("pad+next ndata", nd[0], 16);
        cmp("pad+next done", ndone[0], 2);

        // Reset mid-header with strobe held; bytes after release form a new packet
        clear_mon();
        begin
            vec_t t;
            t = tv[0];
            t.hcut = 10;
            t.after = 0;
            send_pkt(t);
        end
        rst = 1'b1;
        send_byte(8'h55);
        send_byte(8'h55);
        rst = 1'b0;
        send_pkt(tv[0]);
        idle(4);
        cmp("rst-mid nerr", nerr[0], 0);
        cmp("rst-mid ndata", nd[0], 8);
        cmp("rst-mid done", ndone[0], 1);
        cmp("rst-mid src", ifa.rx_src_ip, SRC);

        cmp("onehot/exclusive/last", nviol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/rx_ipv4_parser.md
RX_IPV4_PARSER -- requirements
Module: rx_ipv4_parser

Interface
REQ-001 SHALL provide parameter OCT, default 8, meaning byte width; only 8 is supported.
REQ-002 SHALL provide parameter NPROTO, default 3, meaning number of accepted protocols.
REQ-003 SHALL provide parameter PROTO_LIST, default {8'h01,8'h06,8'h11}, meaning NPROTO*8-bit packed protocol numbers; entry i occupies bits [8i+7:8i].
REQ-004 SHALL provide parameter ACCEPT_BCAST, default 1, meaning destination 255.255.255.255 is accepted when 1.
REQ-005 SHALL provide port RX_CLK  input  1  receive clock; all logic is on the rising edge.
REQ-006 SHALL provide port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL provide port ip_addr  input  32  local IPv4 address, sampled at the last header byte.
REQ-008 SHALL provide port rx_payload_ipv4  input  1  byte strobe; high for consecutive cycles for one packet; low ends the frame.
REQ-009 SHALL provide port rx_payload  input  8  IPv4 byte, valid when rx_payload_ipv4=1.
REQ-010 SHALL provide port rx_data  output  8  forwarded payload byte.
REQ-011 SHALL provide port rx_data_valid  output  NPROTO  one-hot, bit i = rx_data valid for PROTO_LIST entry i.
REQ-012 SHALL provide port rx_data_last  output  1  marks the final payload byte.
REQ-013 SHALL provide port rx_src_ip  output  32  source address of the last accepted packet.
REQ-014 SHALL provide port rx_payload_len  output  16  total_len - IHL*4 of the last accepted packet.
REQ-015 SHALL provide port rx_pkt_done  output  1  one-cycle pulse when a packet completes successfully.
REQ-016 SHALL provide port rx_err  output  1  one-cycle pulse on packet rejection.
REQ-017 SHALL provide port rx_err_code  output  3  reason code, valid with rx_err and held until the next error.

Function
REQ-018 SHALL implement the states IDLE, HDR, OPT, DATA and DROP.
REQ-019 IDLE SHALL go to HDR on the first strobed byte and SHALL capture version/IHL from that byte (upper nibble = version).
REQ-020 HDR SHALL collect bytes 0-19 MSB-first: TOS, total_len, id, flags/frag, TTL, protocol, checksum, src, dst.
REQ-021 After byte 19, HDR SHALL go to OPT if IHL>5, otherwise it SHALL run header checks.
REQ-022 OPT SHALL consume (IHL-5)*4 bytes, include them in the checksum, discard them, and then run header checks.
REQ-023 The checksum SHALL be a 16-bit one's-complement sum over all header words, with end-around carry folded every word; the header is valid iff the final sum = 16'hFFFF.
REQ-024 The checks SHALL be evaluated on the cycle after the last header byte, with code priority: 1 = version!=4 or IHL<5; 7 = total_len<IHL*4; 2 = checksum bad; 3 = dst not ip_addr (and not broadcast-when-enabled); 5 = MF=1 or frag offset!=0; 4 = protocol not in list.
REQ-025 An IHL<5 packet SHALL be rejected at byte 19 and SHALL NOT enter OPT.
REQ-026 On failure the block SHALL pulse rx_err with the code and go to DROP.
REQ-027 On pass the block SHALL latch rx_src_ip and rx_payload_len, and SHALL go to DATA, or to IDLE with an rx_pkt_done pulse if the length is 0.
REQ-028 DATA SHALL forward each byte with one-cycle latency: rx_data and rx_data_valid[i] are registered.
REQ-029 A 16-bit down-counter SHALL load rx_payload_len; the byte reaching count 1 SHALL assert rx_data_last and SHALL pulse rx_pkt_done in the same cycle.
REQ-030 After the last payload byte the block SHALL go to DROP.
REQ-031 Trailing bytes (Ethernet padding) SHALL be consumed in DROP without output.
REQ-032 DROP SHALL return to IDLE when the strobe is low.
REQ-033 The strobe going low in HDR, OPT or DATA before completion SHALL pulse rx_err with code 6 (truncated) and return to IDLE; rx_data_last SHALL NOT assert.
REQ-034 The strobe going low in IDLE or DROP SHALL have no effect beyond entering IDLE.
REQ-035 The header byte counter SHALL be 6 bits and SHALL NOT wrap within a 60-byte header.
REQ-036 A strobe low for one cycle SHALL delimit packets; a new packet SHALL start on the next strobed byte with no dead cycle required.
REQ-037 rx_data_valid SHALL have at most one bit set; rx_data_valid and rx_err SHALL never be high in the same cycle.

Reset
REQ-038 While rst is high the block SHALL enter IDLE, clear the counters and checksum accumulator, and drive rx_data_valid=0, rx_data_last=0, rx_pkt_done=0, rx_err=0, rx_err_code=0, rx_data=0, rx_src_ip=0, rx_payload_len=0.
REQ-039 A reset mid-packet SHALL discard the packet; bytes still strobed after release SHALL be parsed as a new packet.

Verification
REQ-040 A valid UDP packet (IHL=5, total_len=28, dst=ip_addr, src=10.0.0.2, 8 payload bytes) SHALL produce 8 cycles of rx_data_valid=3'b100, rx_data_last plus rx_pkt_done on byte 8, rx_src_ip=0x0A000002 and rx_payload_len=8.
REQ-041 The same packet with one checksum bit flipped SHALL produce rx_err with code 2 and no rx_data_valid.
REQ-042 An IHL=6 packet with a 4-byte option and correct checksum SHALL forward exactly total_len-24 bytes, with no option bytes on rx_data.
REQ-043 A packet with 18 bytes of trailing padding beyond total_len=28 SHALL forward 8 bytes; padding SHALL be silently dropped and the next packet SHALL parse correctly.
REQ-044 A packet with the strobe dropped after payload byte 3 SHALL produce rx_err with code 6 and no rx_data_last.
REQ-045 A broadcast destination SHALL be accepted with ACCEPT_BCAST=1 and rejected with code 3 with ACCEPT_BCAST=0; a frag offset of 1 SHALL be rejected with code 5; protocol 0x02 SHALL be rejected with code 4.
